// File: rtl/triangle_bbox_walker_if.sv
// triangle_bbox_walker_if: triangle intake and pixel stream bundle.
// Revision 1.0 - initial release.
`default_nettype none

interface triangle_bbox_walker_if;
  // Vertices packed {p, q, r}, each {x, y, z}; color packed {r, g, b}.
  logic [143:0] texel_vertices_in;
  logic [23:0]  texel_color_in;
  logic         texel_ready;
  logic         texel_read;
  logic [15:0]  pixel_x;
  logic [15:0]  pixel_y;
  logic [23:0]  pixel_color;
  logic         pixel_valid;
  logic         pixel_ready;
  logic         tri_done;
  logic         busy;

  modport master (
    output texel_vertices_in, texel_color_in, texel_ready, pixel_ready,
    input  texel_read, pixel_x, pixel_y, pixel_color, pixel_valid, tri_done, busy
  );

  modport slave (
    input  texel_vertices_in, texel_color_in, texel_ready, pixel_ready,
    output texel_read, pixel_x, pixel_y, pixel_color, pixel_valid, tri_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/triangle_bbox_walker.sv
// triangle_bbox_walker: clamps a triangle's bounding box to the screen and streams its pixels in raster order.
// Revision 1.0 - initial release.
`default_nettype none

module triangle_bbox_walker #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  wire logic             clk,
  input  wire logic             rst,
  triangle_bbox_walker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WALK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic signed [16:0] c_X_MAX = 17'(SCREEN_WIDTH - 1);
  localparam logic signed [16:0] c_Y_MAX = 17'(SCREEN_HEIGHT - 1);
  localparam logic signed [16:0] c_ZERO  = 17'sd0;

  state_t      r_state;
  logic [15:0] r_px, r_py, r_qx, r_qy, r_rx, r_ry;
  logic [23:0] r_color;
  logic [15:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [15:0] r_cur_x, r_cur_y;
  logic        r_pixel_valid;
  logic        r_tri_done;

  function automatic logic signed [16:0] smin3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    m = (c < m) ? c : m;
    return {m[15], m};
  endfunction

  function automatic logic signed [16:0] smax3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return {m[15], m};
  endfunction

  logic signed [16:0] w_mn_x, w_mx_x, w_mn_y, w_mx_y;
  logic signed [16:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
  logic               w_empty;
  logic               w_accept;
  logic               w_unused_z;

  assign w_mn_x = smin3(r_px, r_qx, r_rx);
  assign w_mx_x = smax3(r_px, r_qx, r_rx);
  assign w_mn_y = smin3(r_py, r_qy, r_ry);
  assign w_mx_y = smax3(r_py, r_qy, r_ry);

  // Clamp in 17-bit signed so negative and off-right coordinates compare correctly.
  assign w_lo_x  = (w_mn_x < c_ZERO)  ? c_ZERO  : w_mn_x;
  assign w_hi_x  = (w_mx_x > c_X_MAX) ? c_X_MAX : w_mx_x;
  assign w_lo_y  = (w_mn_y < c_ZERO)  ? c_ZERO  : w_mn_y;
  assign w_hi_y  = (w_mx_y > c_Y_MAX) ? c_Y_MAX : w_mx_y;
  assign w_empty = (w_lo_x > w_hi_x) || (w_lo_y > w_hi_y);

  assign w_accept   = (r_state == S_WALK) && bus.pixel_ready;
  assign w_unused_z = ^{bus.texel_vertices_in[111:96], bus.texel_vertices_in[63:48],
                        bus.texel_vertices_in[15:0]};

  // Gated by rst so the strobe reads zero while reset is held.
  assign bus.texel_read  = (r_state == S_IDLE) && bus.texel_ready && !rst;
  assign bus.pixel_x     = r_cur_x;
  assign bus.pixel_y     = r_cur_y;
  assign bus.pixel_color = r_color;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.tri_done    = r_tri_done;
  assign bus.busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_px          <= 16'd0;
      r_py          <= 16'd0;
      r_qx          <= 16'd0;
      r_qy          <= 16'd0;
      r_rx          <= 16'd0;
      r_ry          <= 16'd0;
      r_color       <= 24'd0;
      r_min_x       <= 16'd0;
      r_max_x       <= 16'd0;
      r_min_y       <= 16'd0;
      r_max_y       <= 16'd0;
      r_cur_x       <= 16'd0;
      r_cur_y       <= 16'd0;
      r_pixel_valid <= 1'b0;
      r_tri_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tri_done <= 1'b0;
          if (bus.texel_ready) begin
            r_px    <= bus.texel_vertices_in[143:128];
            r_py    <= bus.texel_vertices_in[127:112];
            r_qx    <= bus.texel_vertices_in[95:80];
            r_qy    <= bus.texel_vertices_in[79:64];
            r_rx    <= bus.texel_vertices_in[47:32];
            r_ry    <= bus.texel_vertices_in[31:16];
            r_color <= bus.texel_color_in;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_empty) begin
            r_tri_done <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_min_x       <= w_lo_x[15:0];
            r_max_x       <= w_hi_x[15:0];
            r_min_y       <= w_lo_y[15:0];
            r_max_y       <= w_hi_y[15:0];
            r_cur_x       <= w_lo_x[15:0];
            r_cur_y       <= w_lo_y[15:0];
            r_pixel_valid <= 1'b1;
            r_state       <= S_WALK;
          end
        end
        S_WALK: begin
          if (w_accept) begin
            if (r_cur_x < r_max_x) begin
              r_cur_x <= r_cur_x + 16'd1;
            end else if (r_cur_y < r_max_y) begin
              r_cur_x <= r_min_x;
              r_cur_y <= r_cur_y + 16'd1;
            end else begin
              r_pixel_valid <= 1'b0;
              r_tri_done    <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_tri_done <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_triangle_bbox_walker.sv
// tb_triangle_bbox_walker: directed and randomized triangles checked against a raster-order bounding-box model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_triangle_bbox_walker;

  logic tb_clk = 1'b0;
  logic rst;
  always #5 tb_clk = ~tb_clk;

  triangle_bbox_walker_if bus ();

  triangle_bbox_walker #(
    .SCREEN_WIDTH (640),
    .SCREEN_HEIGHT(480)
  ) dut (
    .clk(tb_clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Expected pixel list: clamped box, rows top to bottom, columns left to right.
  task automatic build_model(input int px, py, qx, qy, rx, ry);
    int lx, hx, ly, hy;
    exp_q.delete();
    lx = imin3(px, qx, rx); if (lx < 0) lx = 0;
    hx = imax3(px, qx, rx); if (hx > 639) hx = 639;
    ly = imin3(py, qy, ry); if (ly < 0) ly = 0;
    hy = imax3(py, qy, ry); if (hy > 479) hy = 479;
    for (int y = ly; y <= hy; y++)
      for (int x = lx; x <= hx; x++)
        exp_q.push_back((x << 16) | y);
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles at pixel index stall_idx
  task automatic run_tri(input string name, input int px, py, qx, qy, rx, ry,
                         input logic [23:0] col, input int mode, input int stall_idx);
    int n_px, stalls, k, first_valid, done_k, held, idx;
    logic rdy;
    logic [31:0] e;
    build_model(px, py, qx, qy, rx, ry);
    n_px = exp_q.size();
    stalls = 0; first_valid = -1; done_k = -1; held = 0;
    bus.texel_vertices_in = {16'(px), 16'(py), 16'($urandom), 16'(qx), 16'(qy), 16'($urandom),
                             16'(rx), 16'(ry), 16'($urandom)};
    bus.texel_color_in = col;
    bus.texel_ready    = 1'b1;
    bus.pixel_ready    = 1'b0;
    #1;
    check({name, ":texel_read"}, bus.texel_read, 1);
    check({name, ":idle_busy"}, bus.busy, 0);
    @(posedge tb_clk); #1;
    bus.texel_ready       = 1'b0;
    bus.texel_vertices_in = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    bus.texel_color_in    = 24'($urandom);
    k = 1;
    check({name, ":setup_valid"}, bus.pixel_valid, 0);
    check({name, ":setup_busy"}, bus.busy, 1);
    while (done_k < 0 && k < 2000) begin
      @(posedge tb_clk); #1;
      k++;
      idx = n_px - exp_q.size();
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (bus.pixel_valid && idx == stall_idx && held < 3) begin
            rdy = 1'b0; held++;
          end else rdy = 1'b1;
        end
      endcase
      bus.pixel_ready = rdy;
      if (bus.tri_done) begin
        done_k = k;
        check({name, ":done_novalid"}, bus.pixel_valid, 0);
      end
      if (bus.pixel_valid) begin
        if (first_valid < 0) first_valid = k;
        if (exp_q.size() == 0) begin
          check({name, ":extra_pixel"}, bus.pixel_valid, 0);
        end else begin
          e = exp_q[0];
          check({name, ":pixel"}, {bus.pixel_x, bus.pixel_y, bus.pixel_color},
                {e[31:16], e[15:0], col});
          if (rdy) void'(exp_q.pop_front());
          else stalls++;
        end
      end
    end
    check({name, ":done_seen"}, (done_k >= 0), 1);
    check({name, ":done_cycle"}, done_k, (n_px == 0) ? 2 : 2 + n_px + stalls);
    if (n_px > 0) check({name, ":first_valid"}, first_valid, 2);
    check({name, ":missing_pixels"}, exp_q.size(), 0);
    @(posedge tb_clk); #1;
    bus.pixel_ready = 1'b0;
    check({name, ":idle_after"}, {bus.busy, bus.tri_done, bus.pixel_valid}, 3'b000);
  endtask

  initial begin
    int bx, by;
    rst = 1'b1;
    bus.texel_vertices_in = '0;
    bus.texel_color_in    = '0;
    bus.texel_ready       = 1'b0;
    bus.pixel_ready       = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1;
    check("reset_outputs", {bus.texel_read, bus.pixel_valid, bus.tri_done, bus.busy},
          4'b0000);
    check("reset_pixel", {bus.pixel_x, bus.pixel_y, bus.pixel_color}, 56'd0);
    rst = 1'b0;
    @(posedge tb_clk); #1;

    run_tri("basic", 2, 3, 4, 3, 3, 5, 24'h112233, 0, 0);
    run_tri("backpressure", 2, 3, 4, 3, 3, 5, 24'h112233, 2, 4);
    run_tri("neg_clamp", -5, -2, 1, 0, 0, 1, 24'hA5A5A5, 0, 0);
    run_tri("high_clamp", 638, 478, 700, 479, 639, 500, 24'h0F1E2D, 0, 0);
    run_tri("offscreen", 700, 10, 710, 20, 720, 15, 24'hFFFFFF, 0, 0);
    run_tri("single_point", 100, 200, 100, 200, 100, 200, 24'h010203, 0, 0);
    run_tri("collinear", 5, 7, 9, 7, 7, 7, 24'h445566, 1, 0);

    // Mid-walk reset with a second triangle already waiting.
    bus.texel_vertices_in = {16'd2, 16'd3, 16'd0, 16'd4, 16'd3, 16'd0, 16'd3, 16'd5, 16'd0};
    bus.texel_color_in    = 24'h112233;
    bus.texel_ready       = 1'b1;
    bus.pixel_ready       = 1'b1;
    #1;
    check("rst:texel_read", bus.texel_read, 1);
    repeat (3) @(posedge tb_clk);
    #1;
    check("rst:walking", bus.pixel_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst:outputs", {bus.texel_read, bus.pixel_valid, bus.tri_done, bus.busy}, 4'b0000);
    check("rst:pixel", {bus.pixel_x, bus.pixel_y, bus.pixel_color}, 56'd0);
    @(posedge tb_clk); #1;
    check("rst:no_done", {bus.tri_done, bus.pixel_valid, bus.busy}, 3'b000);
    rst = 1'b0;
    bus.pixel_ready = 1'b0;
    run_tri("after_rst", 10, 20, 12, 21, 11, 22, 24'h778899, 0, 0);

    for (int t = 0; t < 8; t++) begin
      bx = int'($urandom_range(0, 670)) - 15;
      by = int'($urandom_range(0, 510)) - 15;
      run_tri("random", bx + int'($urandom_range(0, 9)), by + int'($urandom_range(0, 9)),
              bx + int'($urandom_range(0, 9)), by + int'($urandom_range(0, 9)),
              bx + int'($urandom_range(0, 9)), by + int'($urandom_range(0, 9)),
              24'($urandom), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/triangle_bbox_walker.md
# triangle_bbox_walker

Downstream consumer of the texel assembler in the 3D GPU pipeline. Takes one assembled triangle (three 3D vertices plus a flat color) using the assembler's `texel_ready`/`texel_read` handshake. Computes the screen-clamped 2D bounding box of the triangle. Emits every pixel coordinate inside that box in raster order, with the triangle color, over a valid/ready stream to the fragment stage.

## Interface
- `SCREEN_WIDTH`, 640, horizontal resolution; legal x is 0..SCREEN_WIDTH-1.
- `SCREEN_HEIGHT`, 480, vertical resolution; legal y is 0..SCREEN_HEIGHT-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; all state cleared immediately.
- `texel_vertices_in`  in  Triangle3D  vertices p, q, r. Each has x, y, z of 16 bits. x and y are two's-complement pixel coordinates; z is ignored.
- `texel_color_in`  in  Color  flat triangle color (r, g, b, 8 bits each).
- `texel_ready`  in  1  assembler holds a complete triangle.
- `texel_read`  out  1  consume strobe to the assembler. Combinational: `state==IDLE && texel_ready`.
- `pixel_x`  out  16  current pixel x (unsigned).
- `pixel_y`  out  16  current pixel y (unsigned).
- `pixel_color`  out  Color  latched triangle color.
- `pixel_valid`  out  1  pixel_x/pixel_y/pixel_color are valid.
- `pixel_ready`  in  1  downstream accepts the pixel this cycle.
- `tri_done`  out  1  one-cycle pulse: the triangle is fully emitted, or it was empty after clamping.
- `busy`  out  1  high whenever state != IDLE.

## Operation
States are IDLE, SETUP, WALK and DONE.

IDLE
- When `texel_ready` is high: drive `texel_read`=1 that cycle.
- On that edge, latch all vertex x/y values and the color; go to SETUP.

SETUP (exactly one cycle)
- min_x / max_x = signed min / max of p.x, q.x, r.x. Same rule for y.
- Clamp, comparisons signed 17-bit:
  - min_x = max(min_x, 0); max_x = min(max_x, SCREEN_WIDTH-1).
  - Same for y with SCREEN_HEIGHT-1.
- If clamped min_x > max_x or min_y > max_y, the box is empty: go to DONE.
- Otherwise load cur_x=min_x, cur_y=min_y and go to WALK.

WALK
- `pixel_valid`=1; pixel_x=cur_x, pixel_y=cur_y.
- On an edge with `pixel_ready`=1 (accept):
  - if cur_x < max_x: cur_x+1;
  - else if cur_y < max_y: cur_x=min_x, cur_y+1;
  - else (last pixel): go to DONE.
- With `pixel_ready`=0, all pixel outputs hold stable.
- `pixel_valid` never drops without an accept.

DONE (one cycle)
- `tri_done`=1; return to IDLE.
- `texel_read` is not asserted in DONE, even if `texel_ready` is high.

Arithmetic and counting
- Coordinates and counters are 16-bit unsigned after clamping; no wrap is possible because max ≤ SCREEN-1.
- Pixel count = (max_x-min_x+1)*(max_y-min_y+1). It is not computed; it is implicit in the walk.

Degenerate triangles
- Collinear or coincident vertices are walked like any other triangle.
- For example, all three vertices equal gives exactly 1 pixel.

## Timing
Reset values:
- `texel_read`=0, `pixel_valid`=0, `tri_done`=0, `busy`=0.
- pixel_x=0, pixel_y=0, pixel_color=0, state=IDLE.

Pipeline timing (cycle n = cycle where `texel_read` is high):
- SETUP in cycle n+1.
- First `pixel_valid` in cycle n+2.
- Throughput is 1 pixel/cycle while `pixel_ready` is held high.
- For an N-pixel box with no backpressure: last accept at the edge ending cycle n+1+N; `tri_done` in cycle n+2+N; IDLE from cycle n+3+N.
- Empty box: `tri_done` in cycle n+2.

Triangle gap:
- Minimum gap between consecutive `texel_read` pulses is N+3 cycles.

Reset mid-operation:
- Immediate return to IDLE with reset values.
- The latched triangle is discarded; no `tri_done` pulse.
- The assembler's triangle is already consumed.

## Test plan
- Basic walk:
  - Stimulus: p=(2,3), q=(4,3), r=(3,5), color (0x11,0x22,0x33), `texel_ready`=1, `pixel_ready`=1.
  - Response: one `texel_read` pulse; then 9 pixels in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4),(2,5),(3,5),(4,5), each with color 0x11/0x22/0x33.
  - Response: first pixel 2 cycles after `texel_read`; `tri_done` 1 cycle after the last accept.
- Backpressure:
  - Stimulus: same triangle; drop `pixel_ready` for 3 cycles while pixel (3,4) is presented.
  - Response: (3,4) held stable with `pixel_valid`=1 for all 3 cycles; sequence and count unchanged; `tri_done` delayed by 3 cycles.
- Negative clamp:
  - Stimulus: p=(0xFFFB,0xFFFE) i.e. (-5,-2), q=(1,0), r=(0,1).
  - Response: exactly 4 pixels (0,0),(1,0),(0,1),(1,1).
- High-side clamp:
  - Stimulus: p=(638,478), q=(700,479), r=(639,500).
  - Response: pixels (638,478),(639,478),(638,479),(639,479).
- Off-screen triangle:
  - Stimulus: all x in {700,710,720}.
  - Response: `pixel_valid` never asserts; `tri_done` in cycle n+2.
- Back-to-back and mid-walk reset:
  - Stimulus: two triangles queued; `rst` pulsed high during WALK of the first.
  - Response: all outputs return to reset values immediately; no `tri_done`.
  - Response: after reset release, the next `texel_ready` gives a normal `texel_read` and a correct walk.
